// File: rtl/pck_injct_scheduler.sv
// Round-robin scheduler sharing one packet-injector control port among NR sources.
// Latches one legal descriptor, issues it as a single pck_wr once its VC is ready.
module pck_injct_scheduler #(
  parameter int NR       = 4,
  parameter int V        = 4,
  parameter int EAw      = 8,
  parameter int PCK_SIZw = 14,
  parameter int DATAw    = 64,
  parameter int MIN_SIZE = 2,
  parameter int CNTw     = 32,
  parameter int TIMEOUT  = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NR-1:0]            req_i,
  input  logic [NR*V-1:0]          req_vc_i,
  input  logic [NR*PCK_SIZw-1:0]   req_size_i,
  input  logic [NR*EAw-1:0]        req_dest_i,
  input  logic [NR*DATAw-1:0]      req_data_i,
  output logic [NR-1:0]            ack_o,
  output logic [NR-1:0]            rej_o,
  input  logic [V-1:0]             inj_ready_i,
  output logic                     inj_pck_wr_o,
  output logic [V-1:0]             inj_vc_o,
  output logic [PCK_SIZw-1:0]      inj_size_o,
  output logic [EAw-1:0]           inj_endp_o,
  output logic [DATAw-1:0]         inj_data_o,
  output logic [$clog2(NR)-1:0]    owner_o,
  output logic [NR*CNTw-1:0]       pck_cnt_o,
  output logic                     stall_err_o
);
  localparam int PTRw = $clog2(NR);
  localparam int WDw  = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                state_reg;
  logic [PTRw-1:0]       rr_ptr_reg;
  logic [PTRw-1:0]       owner_reg;
  logic [V-1:0]          hold_vc_reg;
  logic [PCK_SIZw-1:0]   hold_size_reg;
  logic [EAw-1:0]        hold_dest_reg;
  logic [DATAw-1:0]      hold_data_reg;
  logic [NR-1:0]         ack_reg;
  logic [NR-1:0]         rej_reg;
  logic [WDw-1:0]        wd_reg;
  logic                  stall_err_reg;

  logic [V-1:0]          vc_arr   [NR];
  logic [PCK_SIZw-1:0]   size_arr [NR];
  logic [EAw-1:0]        dest_arr [NR];
  logic [DATAw-1:0]      data_arr [NR];

  logic                  win_found;
  logic [PTRw-1:0]       win_idx;
  logic                  win_legal;
  logic                  issue;

  genvar gi;
  generate
    for (gi = 0; gi < NR; gi++) begin : g_unpack
      assign vc_arr[gi]   = req_vc_i[gi*V +: V];
      assign size_arr[gi] = req_size_i[gi*PCK_SIZw +: PCK_SIZw];
      assign dest_arr[gi] = req_dest_i[gi*EAw +: EAw];
      assign data_arr[gi] = req_data_i[gi*DATAw +: DATAw];
    end
  endgenerate

  // First requester at or after rr_ptr, wrapping past NR-1.
  always_comb begin : arb
    logic [PTRw:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int i = 0; i < NR; i++) begin
      idx = {1'b0, rr_ptr_reg} + (PTRw+1)'(i);
      if (idx >= (PTRw+1)'(NR))
        idx = idx - (PTRw+1)'(NR);
      if (!win_found && req_i[idx[PTRw-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx[PTRw-1:0];
      end
    end
  end

  assign win_legal = $onehot(vc_arr[win_idx]) &&
                     (size_arr[win_idx] >= PCK_SIZw'(MIN_SIZE));
  assign issue     = (state_reg == HOLD) && (|(inj_ready_i & hold_vc_reg));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      owner_reg     <= '0;
      hold_vc_reg   <= '0;
      hold_size_reg <= '0;
      hold_dest_reg <= '0;
      hold_data_reg <= '0;
      ack_reg       <= '0;
      rej_reg       <= '0;
      wd_reg        <= '0;
      stall_err_reg <= 1'b0;
    end else begin
      ack_reg <= '0;
      rej_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            rr_ptr_reg <= (win_idx == PTRw'(NR-1)) ? '0 : win_idx + PTRw'(1);
            if (win_legal) begin
              hold_vc_reg       <= vc_arr[win_idx];
              hold_size_reg     <= size_arr[win_idx];
              hold_dest_reg     <= dest_arr[win_idx];
              hold_data_reg     <= data_arr[win_idx];
              owner_reg         <= win_idx;
              ack_reg[win_idx]  <= 1'b1;
              wd_reg            <= '0;
              state_reg         <= HOLD;
            end else begin
              rej_reg[win_idx]  <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (issue) begin
            state_reg <= IDLE;
          end else begin
            if (wd_reg != '1)
              wd_reg <= wd_reg + WDw'(1);
            // The incremented count reaching TIMEOUT-1 raises the sticky error.
            if (wd_reg >= WDw'(TIMEOUT-2))
              stall_err_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  generate
    for (gi = 0; gi < NR; gi++) begin : g_cnt
      logic [CNTw-1:0] cnt_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          cnt_reg <= '0;
        else if (issue && (owner_reg == PTRw'(gi)))
          cnt_reg <= cnt_reg + CNTw'(1);
      end
      assign pck_cnt_o[gi*CNTw +: CNTw] = cnt_reg;
    end
  endgenerate

  assign ack_o        = ack_reg;
  assign rej_o        = rej_reg;
  assign inj_pck_wr_o = issue;
  assign inj_vc_o     = hold_vc_reg;
  assign inj_size_o   = hold_size_reg;
  assign inj_endp_o   = hold_dest_reg;
  assign inj_data_o   = hold_data_reg;
  assign owner_o      = owner_reg;
  assign stall_err_o  = stall_err_reg;

endmodule

// File: tb/tb_pck_injct_scheduler.sv
// Randomized bench for pck_injct_scheduler against a transaction-level round-robin model.
module tb_pck_injct_scheduler;
  localparam int NR = 4, V = 4, EAw = 8, PCK_SIZw = 14, DATAw = 64;
  localparam int MIN_SIZE = 2, CNTw = 32, TIMEOUT = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NR-1:0]          req_i;
  logic [NR*V-1:0]        req_vc_i;
  logic [NR*PCK_SIZw-1:0] req_size_i;
  logic [NR*EAw-1:0]      req_dest_i;
  logic [NR*DATAw-1:0]    req_data_i;
  logic [NR-1:0]          ack_o, rej_o;
  logic [V-1:0]           inj_ready_i;
  logic                   inj_pck_wr_o;
  logic [V-1:0]           inj_vc_o;
  logic [PCK_SIZw-1:0]    inj_size_o;
  logic [EAw-1:0]         inj_endp_o;
  logic [DATAw-1:0]       inj_data_o;
  logic [$clog2(NR)-1:0]  owner_o;
  logic [NR*CNTw-1:0]     pck_cnt_o;
  logic                   stall_err_o;

  always #5 clk = ~clk;

  pck_injct_scheduler #(
    .NR(NR), .V(V), .EAw(EAw), .PCK_SIZw(PCK_SIZw), .DATAw(DATAw),
    .MIN_SIZE(MIN_SIZE), .CNTw(CNTw), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(rst_n),
    .req_i(req_i), .req_vc_i(req_vc_i), .req_size_i(req_size_i),
    .req_dest_i(req_dest_i), .req_data_i(req_data_i),
    .ack_o(ack_o), .rej_o(rej_o), .inj_ready_i(inj_ready_i),
    .inj_pck_wr_o(inj_pck_wr_o), .inj_vc_o(inj_vc_o), .inj_size_o(inj_size_o),
    .inj_endp_o(inj_endp_o), .inj_data_o(inj_data_o), .owner_o(owner_o),
    .pck_cnt_o(pck_cnt_o), .stall_err_o(stall_err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: round-robin pointer, issued counts, sticky watchdog flag.
  int          m_rr;
  int unsigned m_cnt [NR];
  bit          m_stall;

  // Source-side descriptors as each source currently presents them.
  bit                  r_req  [NR];
  logic [V-1:0]        r_vc   [NR];
  logic [PCK_SIZw-1:0] r_size [NR];
  logic [EAw-1:0]      r_dest [NR];
  logic [DATAw-1:0]    r_data [NR];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      req_i[i]                        = r_req[i];
      req_vc_i[i*V +: V]              = r_vc[i];
      req_size_i[i*PCK_SIZw +: PCK_SIZw] = r_size[i];
      req_dest_i[i*EAw +: EAw]        = r_dest[i];
      req_data_i[i*DATAw +: DATAw]    = r_data[i];
    end
  endtask

  task automatic new_desc(input int s, input bit ok);
    if (ok || $urandom_range(0, 4) != 0)
      r_vc[s] = V'(1 << $urandom_range(0, V-1));
    else
      r_vc[s] = V'($urandom);
    r_size[s] = ok ? PCK_SIZw'($urandom_range(MIN_SIZE, 40)) : PCK_SIZw'($urandom_range(0, 40));
    r_dest[s] = EAw'($urandom);
    r_data[s] = {$urandom, $urandom};
  endtask

  function automatic int pick();
    for (int k = 0; k < NR; k++)
      if (r_req[(m_rr + k) % NR]) return (m_rr + k) % NR;
    return -1;
  endfunction

  function automatic bit legal(input int s);
    return ($countones(r_vc[s]) == 1) && (r_size[s] >= MIN_SIZE);
  endfunction

  task automatic check_cnt(input int s);
    check_val("cnt", pck_cnt_o[s*CNTw +: CNTw], m_cnt[s]);
  endtask

  task automatic model_reset();
    m_rr = 0;
    m_stall = 0;
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NR; i++) r_req[i] = 0;
    drive_reqs();
  endtask

  // Entered and left 1 time unit after a rising edge with the DUT idle.
  task automatic serve_one(input int stall, input bit drop, input logic [V-1:0] rdy);
    int w;
    bit ok;
    logic [V-1:0]        evc;
    logic [PCK_SIZw-1:0] esz;
    logic [EAw-1:0]      ed;
    logic [DATAw-1:0]    edat;
    drive_reqs();
    w = pick();
    inj_ready_i = V'($urandom);
    #1 check_val("idle_wr", inj_pck_wr_o, 0);
    @(posedge clk); #1;
    if (w < 0) begin
      check_val("idle_ack", ack_o, 0);
      check_val("idle_rej", rej_o, 0);
      $display("txn idle");
      return;
    end
    ok = legal(w);
    m_rr = (w + 1) % NR;
    $display("txn src=%0d legal=%0d stall=%0d", w, ok, stall);
    check_val("ack", ack_o, ok ? (1 << w) : 0);
    check_val("rej", rej_o, ok ? 0 : (1 << w));
    if (!ok) begin
      inj_ready_i = '1;
      #1 check_val("rej_wr", inj_pck_wr_o, 0);
      check_cnt(w);
      if (drop) begin r_req[w] = 0; drive_reqs(); end
      return;
    end
    evc = r_vc[w]; esz = r_size[w]; ed = r_dest[w]; edat = r_data[w];
    check_val("owner", owner_o, w);
    if (drop) begin
      r_req[w] = 0;
      new_desc(w, 0);
      drive_reqs();
    end
    for (int s = 0; s < stall; s++) begin
      inj_ready_i = rdy & ~evc;
      #1 check_val("stall_wr", inj_pck_wr_o, 0);
      @(posedge clk); #1;
      if (s + 1 >= TIMEOUT - 1) m_stall = 1;
      check_val("stall_err", stall_err_o, m_stall);
    end
    inj_ready_i = rdy | evc;
    #1;
    check_val("wr", inj_pck_wr_o, 1);
    check_val("inj_vc", inj_vc_o, evc);
    check_val("inj_size", inj_size_o, esz);
    check_val("inj_endp", inj_endp_o, ed);
    check_val("inj_data", inj_data_o, edat);
    @(posedge clk); #1;
    m_cnt[w]++;
    check_cnt(w);
    check_val("stall_err_post", stall_err_o, m_stall);
    check_val("ack_pulse", ack_o, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout n_checks=%0d", n_checks);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int unsigned base [NR];
    rst_n = 1'b0;
    req_i = '0; req_vc_i = '0; req_size_i = '0; req_dest_i = '0; req_data_i = '0;
    inj_ready_i = '0;
    for (int i = 0; i < NR; i++) begin r_req[i] = 0; new_desc(i, 1); end
    model_reset();
    #1;
    check_val("rst_wr", inj_pck_wr_o, 0);
    check_val("rst_ack", ack_o, 0);
    check_val("rst_rej", rej_o, 0);
    check_val("rst_stall", stall_err_o, 0);
    check_val("rst_owner", owner_o, 0);
    for (int i = 0; i < NR; i++) check_cnt(i);
    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single packet from source 0.
    clear_reqs();
    r_req[0] = 1; r_vc[0] = 4'b0010; r_size[0] = 14'd4;
    serve_one(0, 1, '1);

    // Fairness with every source holding a legal request.
    for (int i = 0; i < NR; i++) begin r_req[i] = 1; new_desc(i, 1); end
    for (int i = 0; i < NR; i++) base[i] = m_cnt[i];
    repeat (8) serve_one(0, 0, '1);
    for (int i = 0; i < NR; i++)
      check_val("fair_cnt", pck_cnt_o[i*CNTw +: CNTw], base[i] + 2);
    clear_reqs();

    // Illegal descriptors: short packet, then non-one-hot VC; pointer must still move.
    r_req[1] = 1; r_vc[1] = 4'b0001; r_size[1] = 14'd1;
    serve_one(0, 1, '1);
    r_req[2] = 1; r_vc[2] = 4'b0110; r_size[2] = 14'd5;
    serve_one(0, 1, '1);
    r_req[1] = 1; new_desc(1, 1);
    r_req[3] = 1; new_desc(3, 1);
    serve_one(0, 1, '1);
    serve_one(0, 1, '1);

    // Randomized traffic with short stalls.
    repeat (60) begin
      for (int i = 0; i < NR; i++)
        if (!r_req[i] && $urandom_range(0, 1) == 1) begin
          new_desc(i, 0);
          r_req[i] = 1;
        end
      serve_one($urandom_range(0, 5), $urandom_range(0, 3) != 0, V'($urandom));
    end
    clear_reqs();
    serve_one(0, 1, '1);

    // Backpressure on VC2 for 20 cycles, tripping the watchdog.
    r_req[1] = 1; r_vc[1] = 4'b0100; r_size[1] = 14'd6;
    serve_one(20, 1, 4'b1011);
    r_req[3] = 1; new_desc(3, 1);
    serve_one(2, 1, '1);

    // Reset while a descriptor is held.
    clear_reqs();
    r_req[2] = 1; new_desc(2, 1);
    drive_reqs();
    inj_ready_i = '0;
    @(posedge clk); #1;
    check_val("rh_ack", ack_o, 4'b0100);
    r_req[2] = 0; drive_reqs();
    repeat (3) @(posedge clk);
    #1 inj_ready_i = '1;
    #1 check_val("rh_pre_wr", inj_pck_wr_o, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("rh_wr", inj_pck_wr_o, 0);
    check_val("rh_vc", inj_vc_o, 0);
    check_val("rh_stall", stall_err_o, 0);
    for (int i = 0; i < NR; i++) check_cnt(i);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin r_req[i] = 1; new_desc(i, 1); end
    serve_one(0, 1, '1);
    serve_one(1, 1, '1);
    clear_reqs();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
